// File: rtl/instr_fetch_issue_pkg.sv
// Shared definitions for the instruction fetch/issue front end: word
// classification bit, half-select encodings and the fetch FSM states.
package instr_fetch_issue_pkg;

    // Bit 31 set marks a single long movl/movh word; clear marks two packed halves.
    localparam int   LONG_BIT   = 31;
    localparam logic HALF_UPPER = 1'b0;
    localparam logic HALF_LOWER = 1'b1;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    function automatic logic is_long(input logic [31:0] word);
        return word[LONG_BIT];
    endfunction

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Bundles the instruction-memory request/response bus and the decoder issue
// bus. The fetch unit is the master; memory plus decoder form the slave side.
interface instr_fetch_issue_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_valid;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  dec_en;
    logic [WIDTH-1:0]      long_instr;
    logic                  instr_choose;
    logic                  dec_ready;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        output mem_req, mem_addr, dec_en, long_instr, instr_choose, pc,
        input  mem_gnt, mem_valid, mem_rdata, dec_ready
    );

    modport slave (
        input  mem_req, mem_addr, dec_en, long_instr, instr_choose, pc,
        output mem_gnt, mem_valid, mem_rdata, dec_ready
    );
endinterface

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue: one outstanding word fetch at a time, each word
// issued as a single long instruction or as upper-then-lower half pair, with
// decoder back-pressure, jump redirects and dropping of stale responses.
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int                  WIDTH      = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_issue_if.master   bus,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    input  logic                  jump_half
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  half_q, half_d;
    // Count of granted responses still to be thrown away. Normally 0 or 1; a
    // second jump while a stale response and a fresh request are both in
    // flight needs a second count, so two bits are kept.
    logic [1:0]            discard_q, discard_d;
    logic                  req_q, req_d;
    logic                  en_q, en_d;
    logic [WIDTH-1:0]      instr_q, instr_d;
    logic                  choose_q, choose_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    logic granted;
    logic drop;
    logic take;
    logic xfer;
    logic last_part;

    assign granted   = req_q & bus.mem_gnt;
    assign drop      = bus.mem_valid & (discard_q != 2'd0);
    assign take      = bus.mem_valid & (discard_q == 2'd0) & (state_q == S_WAIT);
    assign xfer      = en_q & bus.dec_ready;
    assign last_part = instr_q[LONG_BIT] | (choose_q == HALF_LOWER);

    assign bus.mem_req      = req_q;
    assign bus.mem_addr     = addr_q;
    assign bus.dec_en       = en_q;
    assign bus.long_instr   = instr_q;
    assign bus.instr_choose = choose_q;
    assign bus.pc           = pc_q;

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            addr_q    <= RESET_PC;
            half_q    <= HALF_UPPER;
            discard_q <= 2'd0;
            req_q     <= 1'b0;
            en_q      <= 1'b0;
            instr_q   <= '0;
            choose_q  <= HALF_UPPER;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            half_q    <= half_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            en_q      <= en_d;
            instr_q   <= instr_d;
            choose_q  <= choose_d;
            pc_q      <= pc_d;
        end
    end

    // Next-state logic: jumps override everything, otherwise REQ -> WAIT -> ISSUE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        half_d    = half_q;
        discard_d = discard_q;
        en_d      = en_q;
        instr_d   = instr_q;
        choose_d  = choose_q;
        pc_d      = pc_q;

        if (drop) begin
            discard_d = discard_q - 2'd1;
        end

        if (jump_valid) begin
            // A granted request whose data is still out becomes stale.
            if (((state_q == S_WAIT) && !take) || ((state_q == S_REQ) && granted)) begin
                discard_d = discard_d + 2'd1;
            end
            en_d    = 1'b0;
            addr_d  = jump_target;
            half_d  = jump_half;
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (granted) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (take) begin
                        instr_d  = bus.mem_rdata;
                        pc_d     = addr_q;
                        en_d     = 1'b1;
                        choose_d = is_long(bus.mem_rdata) ? HALF_UPPER : half_q;
                        state_d  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        if (last_part) begin
                            en_d    = 1'b0;
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            half_d  = HALF_UPPER;
                            state_d = S_REQ;
                        end else begin
                            choose_d = HALF_LOWER;
                        end
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        req_d = (state_d == S_REQ);
    end

endmodule
